// File: rtl/multicycle_cu_pkg.sv
// multicycle_cu_pkg: FSM states, opcodes, ALUOp codes and the opcode classifier.
// CU_UPPER_IMM_EN adds LUI/AUIPC as legal classes.
package multicycle_cu_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {C_R, C_I, C_LD, C_ST, C_B, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            OP_R:     return C_R;
            OP_I:     return C_I;
            OP_LD:    return C_LD;
            OP_ST:    return C_ST;
            OP_B:     return C_B;
            OP_JAL:   return C_JAL;
            OP_JALR:  return C_JALR;
`ifdef CU_UPPER_IMM_EN
            OP_LUI:   return C_LUI;
            OP_AUIPC: return C_AUIPC;
`endif
            default:  return C_ILL;
        endcase
    endfunction
endpackage

// File: rtl/cu_mem_timer.sv
// cu_mem_timer: counts stalled memory-request cycles and flags a timeout on the cycle
// the count would reach MEM_TIMEOUT; a ready in that same cycle wins.
module cu_mem_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);
    logic [TO_W-1:0] cnt_q, cnt_d;

    // idle cycles hold the count at zero, so each FETCH/MEM starts fresh
    always_comb cnt_d = (req_i && !ready_i) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign timeout_o = 1'b0;
        end else begin : g_on
            assign timeout_o = req_i && !ready_i && cnt_q == TO_W'(MEM_TIMEOUT - 1);
        end
    endgenerate
endmodule

// File: rtl/multicycle_cu.sv
// multicycle_cu: RV32I multi-cycle control FSM with bus timeout, trap state and retire counter.
// CU_UPPER_IMM_EN adds LUI/AUIPC and the ui_sel output.
module multicycle_cu
    import multicycle_cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
    output logic                Jump,
    output logic                Jalr,
    output logic [1:0]          ALUOp,
    output logic                instr_done,
    output logic                illegal,
    output logic                bus_err,
    output logic [RETIRE_W-1:0] retired,
`ifdef CU_UPPER_IMM_EN
    output logic [1:0]          ui_sel,
`endif
    output logic [2:0]          state_o
);
    state_t              state_q, state_d;
    cls_t                cls;
    logic                illegal_q, bus_err_q, timeout;
    logic                in_f, in_e, in_m, in_w, alu_hold;
    logic [RETIRE_W-1:0] retired_q;

    cu_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .req_i    (mem_req),
        .ready_i  (mem_ready),
        .timeout_o(timeout)
    );

    assign cls      = classify(opcode);
    assign in_f     = state_q == S_FETCH;
    assign in_e     = state_q == S_EXEC;
    assign in_m     = state_q == S_MEM;
    assign in_w     = state_q == S_WB;
    assign alu_hold = in_e || in_m || in_w;

    assign mem_req    = in_f || in_m;
    assign ir_write   = in_f && mem_ready;
    assign pc_write   = ir_write;
    assign MemRead    = in_f || (in_m && cls == C_LD);
    assign MemWrite   = in_m && cls == C_ST && !timeout;
    assign RegWrite   = in_w;
    assign MemtoReg   = in_w && cls == C_LD;
    assign Branch     = in_e && cls == C_B;
    assign Jump       = in_e && (cls == C_JAL || cls == C_JALR);
    assign Jalr       = in_e && cls == C_JALR;
    assign ALUSrc     = alu_hold && cls inside {C_I, C_LD, C_ST, C_JALR, C_LUI, C_AUIPC};
    assign ALUOp      = !alu_hold ? ALUOP_ADD : cls == C_B ? ALUOP_BR :
                        (cls == C_R || cls == C_I) ? ALUOP_FN : ALUOP_ADD;
    assign instr_done = in_w || (in_e && cls == C_B) || (in_m && cls == C_ST && mem_ready);
    assign illegal    = illegal_q;
    assign bus_err    = bus_err_q;
    assign retired    = retired_q;
    assign state_o    = state_q;
`ifdef CU_UPPER_IMM_EN
    assign ui_sel     = !alu_hold ? 2'b00 : cls == C_LUI ? 2'b01 : cls == C_AUIPC ? 2'b10 : 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = timeout ? S_TRAP : mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = cls == C_ILL ? S_TRAP : S_EXEC;
            S_EXEC:   state_d = cls inside {C_LD, C_ST} ? S_MEM : cls == C_B ? S_FETCH : S_WB;
            S_MEM:    state_d = timeout ? S_TRAP : !mem_ready ? S_MEM : cls == C_LD ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q || (state_q == S_DECODE && cls == C_ILL);
            bus_err_q <= bus_err_q || timeout;
            retired_q <= retired_q + RETIRE_W'(instr_done);
        end
    end
endmodule

// File: tb/tb_multicycle_cu.sv
// tb_multicycle_cu: random instructions, memory latencies and resets checked every cycle
// against a phase-list reference model of the control unit.
module tb_multicycle_cu;
    localparam int TO = 15;
    localparam int RW = 32;

    logic          clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
    logic [6:0]    opcode = 7'b0110011;
    logic          mem_req, ir_write, pc_write, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic          Branch, Jump, Jalr, instr_done, illegal, bus_err;
    logic [1:0]    ALUOp;
    logic [RW-1:0] retired;
    logic [2:0]    state_o;
`ifdef CU_UPPER_IMM_EN
    logic [1:0]    ui_sel;
`endif

    multicycle_cu #(.MEM_TIMEOUT(TO), .TO_W(4), .RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .Jalr(Jalr), .ALUOp(ALUOp), .instr_done(instr_done), .illegal(illegal),
        .bus_err(bus_err), .retired(retired),
`ifdef CU_UPPER_IMM_EN
        .ui_sel(ui_sel),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // instruction kinds: 0 R, 1 I, 2 load, 3 store, 4 B, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 illegal
    logic [6:0] opc_t [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    int         src_t [10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    int         aop_t [10] = '{2, 2, 0, 0, 1, 0, 0, 0, 0, 0};

    function automatic int kind(input logic [6:0] op);
        for (int j = 0; j < 9; j++) begin
`ifndef CU_UPPER_IMM_EN
            if (j >= 7) continue;
`endif
            if (op == opc_t[j]) return j;
        end
        return 9;
    endfunction

    int         path[$];
    int         pi, waits, stall, k, trapped;
    bit         trap_m, ill_m, be_m, valid;
    logic [31:0] ret_m;
    logic [6:0] nxt_op = 7'b0110011;

    task automatic new_stall();
        int m;
        m = $urandom_range(0, 9);
        stall = m < 7 ? $urandom_range(0, 3) : m == 7 ? TO - 1 : m == 8 ? TO : 0;
    endtask

    task automatic new_instr();
        int r;
        r = $urandom_range(0, 19);
        nxt_op = r < 16 ? opc_t[r % 9] : r == 16 ? 7'h7f : 7'($urandom);
        k = kind(nxt_op);
        path = '{0, 1};
        if (k != 9) path.push_back(2);
        if (k == 2 || k == 3) path.push_back(3);
        if (k != 9 && k != 3 && k != 4) path.push_back(4);
        pi = 0;
    endtask

    task automatic model_reset();
        ret_m = 0; ill_m = 0; be_m = 0; trap_m = 0; trapped = 0; waits = 0; valid = 1;
        new_instr();
        new_stall();
    endtask

    initial begin
        int  cur;
        bit  rst_now, rdy, mreq, to, last, done, act;
        logic [13:0] exp_ctl, got_ctl;
        valid = 0; trap_m = 0; trapped = 0; waits = 0; stall = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_now = i < 2 || (trap_m && trapped >= 3) || $urandom_range(0, 59) == 0;
            reset = rst_now;
            opcode = nxt_op;
            mem_ready = waits >= stall;
            #1;
            if (valid) begin
                cur  = trap_m ? 7 : path[pi];
                rdy  = mem_ready;
                mreq = cur == 0 || cur == 3;
                to   = mreq && !rdy && waits == TO - 1;
                last = !trap_m && pi == path.size() - 1;
                done = last && k != 9 && (!mreq || rdy);
                act  = cur >= 2 && cur <= 4;
                exp_ctl = {mreq, cur == 0 && rdy, cur == 0 && rdy, act && src_t[k] == 1,
                           cur == 4 && k == 2, cur == 4, cur == 0 || (cur == 3 && k == 2),
                           cur == 3 && k == 3 && !to, cur == 2 && k == 4,
                           cur == 2 && (k == 5 || k == 6), cur == 2 && k == 6,
                           act ? 2'(aop_t[k]) : 2'd0, done};
                got_ctl = {mem_req, ir_write, pc_write, ALUSrc, MemtoReg, RegWrite, MemRead,
                           MemWrite, Branch, Jump, Jalr, ALUOp, instr_done};
                check("state", 32'(state_o), 32'(cur));
                check("ctl", 32'(got_ctl), 32'(exp_ctl));
                check("illegal", 32'(illegal), 32'(ill_m));
                check("bus_err", 32'(bus_err), 32'(be_m));
                check("retired", retired, ret_m);
`ifdef CU_UPPER_IMM_EN
                check("ui_sel", 32'(ui_sel), act ? (k == 7 ? 1 : k == 8 ? 2 : 0) : 0);
`endif
                if (rst_now) model_reset();
                else if (trap_m) trapped++;
                else if (to) begin
                    trap_m = 1; be_m = 1;
                end else if (mreq && !rdy) waits++;
                else begin
                    if (mreq) begin
                        waits = 0;
                        new_stall();
                    end
                    if (done) ret_m++;
                    if (cur == 1 && k == 9) begin
                        trap_m = 1; ill_m = 1;
                    end else if (last) new_instr();
                    else pi++;
                end
            end else if (rst_now) model_reset();
            @(posedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
Control unit for the multi-cycle RV32I core: a Moore FSM that sequences FETCH/DECODE/EXEC/MEM/WB and emits per-state datapath controls. Memory uses a req/ready handshake. The block adds a bounded-wait bus timeout, a trap state and a retired-instruction counter. It sits between the instruction register (opcode) and the shared datapath/memory port.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ready before bus error; 0 = no timeout
TO_W, 4, width of wait counter (must hold MEM_TIMEOUT)
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  7  instr[6:0] from IR; sampled in DECODE/EXEC/MEM/WB
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request (FETCH, MEM)
ir_write  out  1  load IR (FETCH && mem_ready)
pc_write  out  1  PC <= PC+4 (FETCH && mem_ready)
ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, Jalr  out  1 each  datapath controls, per-state (below)
ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
instr_done  out  1  1-cycle pulse on last cycle of each instruction
illegal  out  1  sticky: unknown opcode trapped
bus_err  out  1  sticky: memory timeout trapped
retired  out  RETIRE_W  count of completed instructions, wraps modulo 2^RETIRE_W
state_o  out  3  current state encoding, debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Reset -> FETCH; all outputs 0, retired=0, wait counter=0, illegal/bus_err=0.
- reset has priority in any state, including mid-wait and TRAP.
- FETCH: mem_req=1, MemRead=1. mem_ready=1 -> ir_write=1, pc_write=1, go DECODE; else stay.
- DECODE (1 cycle): opcode in {0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 B, 1101111 JAL, 1100111 JALR} -> EXEC; otherwise -> TRAP, illegal<=1.
- EXEC: ALUSrc/ALUOp/Branch/Jump/Jalr per class: R (0,10), I (1,10), load/store (1,00), B (0,01, Branch=1), JAL (0,00, Jump=1), JALR (1,00, Jump=1, Jalr=1). Next: load/store -> MEM; B -> FETCH with instr_done; all others -> WB.
- MEM: mem_req=1; load MemRead=1, store MemWrite=1. On mem_ready: load -> WB; store -> FETCH with instr_done.
- WB: RegWrite=1; MemtoReg=1 for load only; instr_done=1; -> FETCH.
- Controls not listed for a state are 0. ALUSrc/ALUOp are held in MEM/WB at their EXEC values.
- Cycle counts with zero-wait memory: B=3; R/I/store/JAL/JALR=4; load=5.
- Wait counter: clears on entering FETCH/MEM and on mem_ready; increments each mem_req && !mem_ready cycle. Reaching MEM_TIMEOUT (≠0) -> TRAP, bus_err<=1, no write-enables that cycle.
- mem_ready arriving in the same cycle the count would hit MEM_TIMEOUT counts as success.
- TRAP: all controls 0, mem_req=0; held until reset.
- retired += 1 on every instr_done cycle.

Optional Feature:
CU_UPPER_IMM_EN: when defined, adds LUI (0110111) and AUIPC (0010111) as 4-cycle writeback classes (EXEC ALUSrc=1, ALUOp=00; WB RegWrite=1). Adds output port ui_sel[1:0]: 01 LUI, 10 AUIPC, else 00, valid EXEC through WB. When undefined, the port is absent and both opcodes trap as illegal.

Decomposition:
- Package multicycle_cu_pkg: state enum (3-bit), opcode localparams, ALUOp encodings.
- Sub-module cu_mem_timer: wait counter plus timeout compare, parametrised by MEM_TIMEOUT/TO_W. FSM stays in the top module.

Test Plan:
- Reset then R-type 0110011, mem_ready tied 1 -> states 0,1,2,4; RegWrite=1 in WB only; instr_done once; retired=1.
- Load 0000011, mem_ready low for 3 cycles in MEM -> stays in MEM 4 cycles, MemRead=1 throughout; WB with MemtoReg=1; 8 cycles total.
- Branch 1100011 -> 3 cycles, Branch=1 & ALUOp=01 in EXEC, no RegWrite.
- Opcode 1111111 -> TRAP after DECODE, illegal=1 sticky; reset clears it and returns to FETCH.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> bus_err=1 on cycle 15; mem_ready=1 on cycle 15 instead -> normal DECODE.
- Reset asserted mid-MEM store -> next cycle FETCH, MemWrite=0, retired unchanged (0); with CU_UPPER_IMM_EN, LUI -> ui_sel=01, 4 cycles.
